dram_read_ctrl: RTL and testbench

- Sits directly upstream of the read pipeline's DRAM ports.
- Accepts chunk read addresses on the dramra rdy/ack channel and issues them to the memory request bus through a one-entry register stage.
- Buffers the in-order chunk responses in a credit-protected FIFO and delivers them on the dramrd rdy/ack channel as CSIZE-word chunks.
- The credit counter bounds outstanding requests, so no response is ever dropped.

---
 rtl/dram_read_ctrl_if.sv | 34 +++
 rtl/dram_read_ctrl.sv | 116 +++++++++++
 tb/tb_dram_read_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_read_ctrl_if.sv
// Handshake and data bundle between the read pipeline, dram_read_ctrl and the memory port.
// The slave modport is the controller's view; master is the surrounding environment.
interface dram_read_ctrl_if #(
  parameter int unsigned GBW   = 32,
  parameter int unsigned DBW   = 16,
  parameter int unsigned CSIZE = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_BW = $clog2(DEPTH + 1);

  logic                       dramra_rdy;
  logic                       dramra_ack;
  logic [GBW-1:0]             i_dramra;
  logic                       mem_req_rdy;
  logic                       mem_req_ack;
  logic [GBW-1:0]             o_mem_addr;
  logic                       i_mem_resp_dval;
  logic [CSIZE-1:0][DBW-1:0]  i_mem_rdata;
  logic                       dramrd_rdy;
  logic                       dramrd_ack;
  logic [CSIZE-1:0][DBW-1:0]  o_dramrd;
  logic [CNT_BW-1:0]          o_outstanding;
  logic                       o_err;

  modport slave (
    input  dramra_rdy, i_dramra, mem_req_ack, i_mem_resp_dval, i_mem_rdata, dramrd_ack,
    output dramra_ack, mem_req_rdy, o_mem_addr, dramrd_rdy, o_dramrd, o_outstanding, o_err
  );

  modport master (
    output dramra_rdy, i_dramra, mem_req_ack, i_mem_resp_dval, i_mem_rdata, dramrd_ack,
    input  dramra_ack, mem_req_rdy, o_mem_addr, dramrd_rdy, o_dramrd, o_outstanding, o_err
  );
endinterface

// File: rtl/dram_read_ctrl.sv
// Chunk read controller: one-entry request stage toward memory, credit-bounded
// in-order response FIFO toward the read pipeline, sticky protocol error flag.
module dram_read_ctrl #(
  parameter int unsigned GBW   = 32,
  parameter int unsigned DBW   = 16,
  parameter int unsigned CSIZE = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dram_read_ctrl_if.slave    bus
);
  localparam int unsigned CNT_BW = $clog2(DEPTH + 1);
  localparam int unsigned IDX_BW = $clog2(DEPTH);
  localparam int unsigned PTR_BW = IDX_BW + 1;
  localparam logic [GBW-1:0] ALIGN_MASK = ~GBW'(CSIZE - 1);

  typedef logic [CSIZE-1:0][DBW-1:0] chunk_t;

  logic              req_v_q, req_v_d;
  logic [GBW-1:0]    req_addr_q, req_addr_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [CNT_BW-1:0] pend_q, pend_d;
  logic [PTR_BW-1:0] wptr_q, wptr_d;
  logic [PTR_BW-1:0] rptr_q, rptr_d;
  logic              err_q, err_d;
  chunk_t            mem_q [DEPTH];

  logic empty, full, accept, issue, rd, pend_nz, resp_ret, wr;

  // Handshake qualifiers; accept is held low while reset is asserted
  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[PTR_BW-1] != rptr_q[PTR_BW-1]) &&
               (wptr_q[IDX_BW-1:0] == rptr_q[IDX_BW-1:0]);
    accept   = i_rst && bus.dramra_rdy && (!req_v_q || bus.mem_req_ack) &&
               (cnt_q < CNT_BW'(DEPTH));
    issue    = req_v_q && bus.mem_req_ack;
    rd       = bus.dramrd_ack && !empty;
    pend_nz  = (pend_q != '0);
    resp_ret = bus.i_mem_resp_dval && pend_nz;
    wr       = resp_ret && !full;
  end

  always_comb begin
    req_v_d    = req_v_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q;

    if (accept) begin
      req_v_d    = 1'b1;
      req_addr_d = bus.i_dramra & ALIGN_MASK;
    end else if (issue) begin
      req_v_d    = 1'b0;
    end

    unique case ({accept, rd})
      2'b10:   cnt_d = cnt_q + CNT_BW'(1);
      2'b01:   cnt_d = cnt_q - CNT_BW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Issued-but-unreturned requests; an unexpected response does not decrement
    unique case ({issue, resp_ret})
      2'b10:   pend_d = pend_q + CNT_BW'(1);
      2'b01:   pend_d = pend_q - CNT_BW'(1);
      default: pend_d = pend_q;
    endcase

    if (wr) wptr_d = wptr_q + PTR_BW'(1);
    if (rd) rptr_d = rptr_q + PTR_BW'(1);

    if (bus.i_mem_resp_dval && (!pend_nz || full)) err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      req_v_q    <= 1'b0;
      req_addr_q <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      req_v_q    <= req_v_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end

  // Response storage; cleared so the head reads zero out of reset
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr) begin
      mem_q[wptr_q[IDX_BW-1:0]] <= bus.i_mem_rdata;
    end
  end

  assign bus.dramra_ack    = accept;
  assign bus.mem_req_rdy   = req_v_q;
  assign bus.o_mem_addr    = req_addr_q;
  assign bus.dramrd_rdy    = !empty;
  assign bus.o_dramrd      = mem_q[rptr_q[IDX_BW-1:0]];
  assign bus.o_outstanding = cnt_q;
  assign bus.o_err         = err_q;
endmodule

// File: tb/tb_dram_read_ctrl.sv
// Directed bench for dram_read_ctrl: single read, credit stall, backpressure,
// concurrent traffic with ordering, async reset and unexpected-response error.
module tb_dram_read_ctrl;
  localparam int unsigned GBW   = 32;
  localparam int unsigned DBW   = 16;
  localparam int unsigned CSIZE = 32;
  localparam int unsigned DEPTH = 4;

  typedef logic [CSIZE-1:0][DBW-1:0] chunk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  dram_read_ctrl_if #(.GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .DEPTH(DEPTH)) bus ();

  dram_read_ctrl #(.GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dramra_rdy      = 1'b0;
    bus.i_dramra        = '0;
    bus.mem_req_ack     = 1'b0;
    bus.i_mem_resp_dval = 1'b0;
    bus.i_mem_rdata     = '0;
    bus.dramrd_ack      = 1'b0;
  endtask

  function automatic chunk_t seq_chunk(input int base);
    chunk_t c;
    for (int k = 0; k < int'(CSIZE); k++) c[k] = DBW'(base + k);
    return c;
  endfunction

  function automatic chunk_t rand_chunk();
    chunk_t c;
    for (int k = 0; k < int'(CSIZE); k++) c[k] = DBW'($urandom);
    return c;
  endfunction

  function automatic logic [GBW-1:0] addr_a(input int i);
    return 32'h2000_0005 + GBW'(i) * 32'h48;
  endfunction

  chunk_t         exp_q[$];
  chunk_t         r;
  logic [GBW-1:0] last_addr, nxt;

  initial begin
    idle();
    #12;
    chk("rst_dramra_ack", bus.dramra_ack, 1'b0);
    chk("rst_mem_req_rdy", bus.mem_req_rdy, 1'b0);
    chk("rst_dramrd_rdy", bus.dramrd_rdy, 1'b0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'h0);
    chk("rst_dramrd", bus.o_dramrd, '0);
    chk("rst_outstanding", bus.o_outstanding, 3'd0);
    chk("rst_err", bus.o_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Single read
    bus.dramra_rdy = 1'b1; bus.i_dramra = 32'h1234_5678; #1;
    chk("t1_ra_ack", bus.dramra_ack, 1'b1);
    step();
    bus.dramra_rdy = 1'b0; #1;
    chk("t1_req_rdy", bus.mem_req_rdy, 1'b1);
    chk("t1_mem_addr", bus.o_mem_addr, 32'h1234_5660);
    chk("t1_outst1", bus.o_outstanding, 3'd1);
    bus.mem_req_ack = 1'b1;
    step();
    bus.mem_req_ack = 1'b0; #1;
    chk("t1_req_drop", bus.mem_req_rdy, 1'b0);
    bus.i_mem_resp_dval = 1'b1; bus.i_mem_rdata = seq_chunk(0); #1;
    chk("t1_no_bypass", bus.dramrd_rdy, 1'b0);
    step();
    bus.i_mem_resp_dval = 1'b0; #1;
    chk("t1_rd_rdy", bus.dramrd_rdy, 1'b1);
    chk("t1_data", bus.o_dramrd, seq_chunk(0));
    chk("t1_err", bus.o_err, 1'b0);
    bus.dramrd_ack = 1'b1;
    step();
    bus.dramrd_ack = 1'b0; #1;
    chk("t1_outst0", bus.o_outstanding, 3'd0);
    chk("t1_empty", bus.dramrd_rdy, 1'b0);

    // Credit stall: four accepted, fifth held until a chunk is consumed
    bus.dramra_rdy = 1'b1; bus.i_dramra = addr_a(0); #1;
    chk("t2_ack0", bus.dramra_ack, 1'b1);
    step();
    for (int i = 1; i < 4; i++) begin
      bus.i_dramra = addr_a(i); bus.mem_req_ack = 1'b1; #1;
      chk("t2_ack_n", bus.dramra_ack, 1'b1);
      step();
    end
    bus.i_dramra = addr_a(4); #1;
    chk("t2_ack4_held", bus.dramra_ack, 1'b0);
    chk("t2_outst4", bus.o_outstanding, 3'd4);
    chk("t2_addr3", bus.o_mem_addr, addr_a(3) & 32'hFFFF_FFE0);
    step();
    bus.mem_req_ack = 1'b0; #1;
    chk("t2_still_held", bus.dramra_ack, 1'b0);
    chk("t2_req_idle", bus.mem_req_rdy, 1'b0);
    bus.i_mem_resp_dval = 1'b1; bus.i_mem_rdata = seq_chunk(100);
    step();
    bus.i_mem_resp_dval = 1'b0; #1;
    chk("t2_rd_rdy", bus.dramrd_rdy, 1'b1);
    chk("t2_data0", bus.o_dramrd, seq_chunk(100));
    bus.dramrd_ack = 1'b1; #1;
    chk("t2_same_cyc_held", bus.dramra_ack, 1'b0);
    step();
    bus.dramrd_ack = 1'b0; #1;
    chk("t2_fifth_ack", bus.dramra_ack, 1'b1);
    chk("t2_outst3", bus.o_outstanding, 3'd3);
    step();
    bus.dramra_rdy = 1'b0; #1;
    chk("t2_addr4", bus.o_mem_addr, addr_a(4) & 32'hFFFF_FFE0);
    chk("t2_outst4b", bus.o_outstanding, 3'd4);
    bus.mem_req_ack = 1'b1;
    step();
    bus.mem_req_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.i_mem_resp_dval = 1'b1; bus.i_mem_rdata = seq_chunk(100 + 32 * i);
      step();
    end
    bus.i_mem_resp_dval = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_order", bus.o_dramrd, seq_chunk(100 + 32 * i));
      bus.dramrd_ack = 1'b1;
      step();
      bus.dramrd_ack = 1'b0;
    end
    #1;
    chk("t2_drained", bus.o_outstanding, 3'd0);
    chk("t2_empty", bus.dramrd_rdy, 1'b0);
    chk("t2_err", bus.o_err, 1'b0);

    // Backpressure: request held stable for three cycles
    bus.dramra_rdy = 1'b1; bus.i_dramra = 32'h3000_00FF; #1;
    chk("t3_ack0", bus.dramra_ack, 1'b1);
    step();
    bus.i_dramra = 32'h3000_0401;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_ack", bus.dramra_ack, 1'b0);
      chk("t3_hold_rdy", bus.mem_req_rdy, 1'b1);
      chk("t3_hold_addr", bus.o_mem_addr, 32'h3000_00E0);
      step();
    end
    bus.mem_req_ack = 1'b1; #1;
    chk("t3_ack1", bus.dramra_ack, 1'b1);
    step();
    bus.dramra_rdy = 1'b0; #1;
    chk("t3_rdy1", bus.mem_req_rdy, 1'b1);
    chk("t3_addr1", bus.o_mem_addr, 32'h3000_0400);
    step();
    bus.mem_req_ack = 1'b0; #1;
    chk("t3_idle", bus.mem_req_rdy, 1'b0);
    chk("t3_outst2", bus.o_outstanding, 3'd2);

    // Concurrent write, read and accept with two credits in use
    bus.i_mem_resp_dval = 1'b1; bus.i_mem_rdata = seq_chunk(500);
    step();
    bus.i_mem_rdata = seq_chunk(600); bus.dramrd_ack = 1'b1;
    bus.dramra_rdy = 1'b1; bus.i_dramra = 32'h4000_0010; #1;
    chk("t4_ack", bus.dramra_ack, 1'b1);
    chk("t4_head0", bus.o_dramrd, seq_chunk(500));
    step();
    bus.i_mem_resp_dval = 1'b0; bus.dramrd_ack = 1'b0; bus.dramra_rdy = 1'b0; #1;
    chk("t4_outst2", bus.o_outstanding, 3'd2);
    chk("t4_rd_rdy", bus.dramrd_rdy, 1'b1);
    chk("t4_head1", bus.o_dramrd, seq_chunk(600));
    bus.mem_req_ack = 1'b1; bus.dramra_rdy = 1'b1; bus.i_dramra = 32'h4000_0033;
    step();
    exp_q.push_back(seq_chunk(600));
    last_addr = 32'h4000_0033;
    for (int i = 0; i < 16; i++) begin
      r   = rand_chunk();
      nxt = 32'h5000_0007 + GBW'(i) * 32'h40;
      bus.i_dramra = nxt; bus.dramra_rdy = 1'b1; bus.mem_req_ack = 1'b1;
      bus.i_mem_resp_dval = 1'b1; bus.i_mem_rdata = r; bus.dramrd_ack = 1'b1; #1;
      chk("t4_order", bus.o_dramrd, exp_q[0]);
      chk("t4_loop_ack", bus.dramra_ack, 1'b1);
      chk("t4_loop_addr", bus.o_mem_addr, last_addr & 32'hFFFF_FFE0);
      void'(exp_q.pop_front());
      exp_q.push_back(r);
      last_addr = nxt;
      step();
      chk("t4_loop_outst", bus.o_outstanding, 3'd3);
      chk("t4_loop_rdy", bus.dramrd_rdy, 1'b1);
    end
    idle(); #1;
    chk("t4_err", bus.o_err, 1'b0);
    chk("t4_outst3", bus.o_outstanding, 3'd3);

    // Async reset with three chunks outstanding
    #2;
    bus.dramra_rdy = 1'b1; bus.i_dramra = 32'h7000_0000;
    rst_n = 1'b0; #1;
    chk("t5_ra_ack", bus.dramra_ack, 1'b0);
    chk("t5_req_rdy", bus.mem_req_rdy, 1'b0);
    chk("t5_rd_rdy", bus.dramrd_rdy, 1'b0);
    chk("t5_addr", bus.o_mem_addr, 32'h0);
    chk("t5_data", bus.o_dramrd, '0);
    chk("t5_outst", bus.o_outstanding, 3'd0);
    chk("t5_err", bus.o_err, 1'b0);
    step();
    bus.dramra_rdy = 1'b0; #2;
    rst_n = 1'b1;
    step();

    // Stale response after reset: error, write suppressed, sticky
    bus.i_mem_resp_dval = 1'b1; bus.i_mem_rdata = seq_chunk(700);
    step();
    bus.i_mem_resp_dval = 1'b0; #1;
    chk("t6_err", bus.o_err, 1'b1);
    chk("t6_empty", bus.dramrd_rdy, 1'b0);
    step();
    chk("t6_sticky", bus.o_err, 1'b1);
    chk("t6_outst", bus.o_outstanding, 3'd0);

    // Fresh traffic after reset
    bus.dramra_rdy = 1'b1; bus.i_dramra = 32'h6000_003F; #1;
    chk("t7_ack", bus.dramra_ack, 1'b1);
    step();
    bus.dramra_rdy = 1'b0; bus.mem_req_ack = 1'b1; #1;
    chk("t7_addr", bus.o_mem_addr, 32'h6000_0020);
    step();
    bus.mem_req_ack = 1'b0; bus.i_mem_resp_dval = 1'b1; bus.i_mem_rdata = seq_chunk(800);
    step();
    bus.i_mem_resp_dval = 1'b0; #1;
    chk("t7_data", bus.o_dramrd, seq_chunk(800));
    chk("t7_rd_rdy", bus.dramrd_rdy, 1'b1);
    bus.dramrd_ack = 1'b1;
    step();
    bus.dramrd_ack = 1'b0; #1;
    chk("t7_outst", bus.o_outstanding, 3'd0);
    chk("t7_err_kept", bus.o_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
